// File: rtl/kfpga_pkg.sv
// Shared sizing helpers for kfpga tiles: select-field widths, pad/track field
// offsets and config chain length, shared by RTL, chain tools and benches.
package kfpga_pkg;

  // Select fields are never narrower than one bit, so single-entry muxes still slice cleanly.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return (result < 1) ? 1 : result;
  endfunction

  function automatic int pad_field_w(input int so);
    return so + 2;
  endfunction

  function automatic int track_base(input int pads, input int so);
    return pads * pad_field_w(so);
  endfunction

  function automatic int config_width(input int pads, input int ic_width);
    return track_base(pads, clog2(ic_width)) + ic_width * clog2(pads);
  endfunction

endpackage

// File: rtl/io_tile_config_dbuf.sv
// Double-buffered config store: serial shadow chain plus an active copy that
// only changes on commit, so shifting never disturbs live routing.
module io_tile_config_dbuf #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             config_in,
  input  logic             config_enable,
  input  logic             config_commit,
  output logic             config_out,
  output logic [WIDTH-1:0] config_active
);

  logic [WIDTH-1:0] shadow_d, shadow_q;
  logic [WIDTH-1:0] active_d, active_q;

  // Commit copies the pre-edge shadow, so a same-cycle shift is not seen until the next commit.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (config_enable) shadow_d = {shadow_q[WIDTH-2:0], config_in};
    if (config_commit) active_d = shadow_q;
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign config_out    = shadow_q[WIDTH-1];
  assign config_active = active_q;

endmodule

// File: rtl/io_tile_top_reg.sv
// Fabric-edge IO tile: configurable track-to-pad and pad-to-track muxes with
// an optional register per pad in each direction.
module io_tile_top_reg
  import kfpga_pkg::*;
#(
  parameter int PADS     = 4,
  parameter int IC_WIDTH = 6
) (
  input  logic                clock,
  input  logic                nreset,
  input  logic                config_in,
  input  logic                config_enable,
  input  logic                config_commit,
  output logic                config_out,
  input  logic [PADS-1:0]     data_from_io,
  output logic [PADS-1:0]     data_to_io,
  input  logic [IC_WIDTH-1:0] data_from_ic,
  output logic [IC_WIDTH-1:0] data_to_ic
);

  localparam int SO           = clog2(IC_WIDTH);
  localparam int SI           = clog2(PADS);
  localparam int PW           = pad_field_w(SO);
  localparam int TBASE        = track_base(PADS, SO);
  localparam int CONFIG_WIDTH = config_width(PADS, IC_WIDTH);

  logic [CONFIG_WIDTH-1:0] active;
  logic [PADS-1:0]         sel_o;
  logic [PADS-1:0]         pin;
  logic [PADS-1:0]         oq_d, oq_q;
  logic [PADS-1:0]         iq_d, iq_q;

  io_tile_config_dbuf #(
    .WIDTH(CONFIG_WIDTH)
  ) u_cfg (
    .clock         (clock),
    .nreset        (nreset),
    .config_in     (config_in),
    .config_enable (config_enable),
    .config_commit (config_commit),
    .config_out    (config_out),
    .config_active (active)
  );

  for (genvar p = 0; p < PADS; p++) begin : g_pad
    logic [SO-1:0] osel;
    logic          oreg;
    logic          ireg;
    logic          sel_bit;

    assign osel = active[p*PW +: SO];
    assign oreg = active[p*PW + SO];
    assign ireg = active[p*PW + SO + 1];

    // Out-of-range selects match no track and leave the pad driving 0.
    always_comb begin
      sel_bit = 1'b0;
      for (int j = 0; j < IC_WIDTH; j++) begin
        if (osel == SO'(j)) sel_bit = data_from_ic[j];
      end
    end

    assign sel_o[p]      = sel_bit;
    assign data_to_io[p] = oreg ? oq_q[p] : sel_o[p];
    assign pin[p]        = ireg ? iq_q[p] : data_from_io[p];
  end

  // Both pipeline registers sample every edge, so flipping oreg/ireg needs no flush.
  always_comb begin
    oq_d = sel_o;
    iq_d = data_from_io;
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      oq_q <= '0;
      iq_q <= '0;
    end else begin
      oq_q <= oq_d;
      iq_q <= iq_d;
    end
  end

  for (genvar i = 0; i < IC_WIDTH; i++) begin : g_track
    logic [SI-1:0] isel;
    logic          trk_bit;

    assign isel = active[TBASE + i*SI +: SI];

    always_comb begin
      trk_bit = 1'b0;
      for (int j = 0; j < PADS; j++) begin
        if (isel == SI'(j)) trk_bit = pin[j];
      end
    end

    assign data_to_ic[i] = trk_bit;
  end

endmodule

// File: tb/tb_io_tile_top_reg.sv
// Directed bench for io_tile_top_reg with default parameters (32-bit chain).
module tb_io_tile_top_reg;

  logic       clock;
  logic       nreset;
  logic       config_in;
  logic       config_enable;
  logic       config_commit;
  logic       config_out;
  logic [3:0] data_from_io;
  logic [3:0] data_to_io;
  logic [5:0] data_from_ic;
  logic [5:0] data_to_ic;

  int checks;
  int errors;

  io_tile_top_reg #(
    .PADS(4),
    .IC_WIDTH(6)
  ) dut (
    .clock         (clock),
    .nreset        (nreset),
    .config_in     (config_in),
    .config_enable (config_enable),
    .config_commit (config_commit),
    .config_out    (config_out),
    .data_from_io  (data_from_io),
    .data_to_io    (data_to_io),
    .data_from_ic  (data_from_ic),
    .data_to_ic    (data_to_ic)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Pad p field at bits [p*5 +: 5] = {ireg, oreg, osel[2:0]}.
  function automatic logic [31:0] pad_f(input int p, input logic [2:0] osel,
                                        input logic oreg, input logic ireg);
    logic [31:0] w;
    w = '0;
    w[p*5 +: 3] = osel;
    w[p*5 + 3]  = oreg;
    w[p*5 + 4]  = ireg;
    return w;
  endfunction

  // Track i field at bits [20 + i*2 +: 2].
  function automatic logic [31:0] trk_f(input int i, input logic [1:0] isel);
    logic [31:0] w;
    w = '0;
    w[20 + i*2 +: 2] = isel;
    return w;
  endfunction

  // MSB goes in first so that after 32 shifts shadow == w.
  task automatic shift_word(input logic [31:0] w);
    for (int k = 31; k >= 0; k--) begin
      config_in     = w[k];
      config_enable = 1'b1;
      tick();
    end
    config_enable = 1'b0;
    config_in     = 1'b0;
  endtask

  task automatic commit();
    config_commit = 1'b1;
    tick();
    config_commit = 1'b0;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    nreset        = 1'b0;
    config_in     = 1'b0;
    config_enable = 1'b0;
    config_commit = 1'b0;
    data_from_ic  = 6'b000001;
    data_from_io  = 4'b0001;
    tick();
    tick();

    check("reset_config_out", {31'b0, config_out}, 32'd0);
    check("reset_to_io", {28'b0, data_to_io}, 32'h0000000f);
    check("reset_to_ic", {26'b0, data_to_ic}, 32'h0000003f);

    nreset = 1'b1;
    tick();

    // All-ones config: every osel=7 (out of range), oreg=1, so pads read 0 via oq.
    shift_word(32'hffffffff);
    check("ones_config_out", {31'b0, config_out}, 32'd1);
    commit();
    tick();
    check("ones_to_io", {28'b0, data_to_io}, 32'h00000000);

    // Partial shift, then asynchronous reset between edges.
    config_enable = 1'b1;
    config_in     = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    #2;
    nreset = 1'b0;
    #1;
    check("midshift_config_out", {31'b0, config_out}, 32'd0);
    check("midshift_to_io", {28'b0, data_to_io}, 32'h0000000f);
    check("midshift_to_ic", {26'b0, data_to_ic}, 32'h0000003f);
    config_enable = 1'b0;
    config_in     = 1'b0;
    tick();
    nreset = 1'b1;
    tick();

    // Chain length: lone 1 then 31 zeros.
    config_enable = 1'b1;
    config_in     = 1'b1;
    tick();
    config_in = 1'b0;
    for (int k = 0; k < 30; k++) tick();
    check("chain_31", {31'b0, config_out}, 32'd0);
    tick();
    check("chain_32", {31'b0, config_out}, 32'd1);
    config_enable = 1'b0;
    check("chain_no_route_change", {28'b0, data_to_io}, 32'h0000000f);

    // Combinational route: pad0 osel=5.
    data_from_ic = 6'b000000;
    shift_word(pad_f(0, 3'd5, 1'b0, 1'b0));
    commit();
    data_from_ic = 6'b100000;
    #1;
    check("comb_pad0_hi", {28'b0, data_to_io}, 32'h00000001);
    data_from_ic = 6'b011111;
    #1;
    check("comb_pad0_lo", {28'b0, data_to_io}, 32'h0000000e);

    // Out-of-range osel=7.
    shift_word(pad_f(0, 3'd7, 1'b0, 1'b0));
    commit();
    data_from_ic = 6'b111111;
    #1;
    check("comb_osel_oor", {28'b0, data_to_io}, 32'h0000000e);

    // Registered route: pad1 oreg=1, osel=2.
    data_from_ic = 6'b000000;
    shift_word(pad_f(1, 3'd2, 1'b1, 1'b0));
    commit();
    tick();
    check("reg_idle", {28'b0, data_to_io}, 32'h00000000);
    data_from_ic = 6'b000100;
    #1;
    check("reg_same_cycle", {28'b0, data_to_io}, 32'h00000000);
    tick();
    data_from_ic = 6'b000000;
    #1;
    check("reg_next_cycle", {28'b0, data_to_io}, 32'h00000002);
    tick();
    check("reg_after_pulse", {28'b0, data_to_io}, 32'h00000000);

    // Input path: track3 isel=2, pad2 ireg=1.
    data_from_io = 4'b0000;
    shift_word(trk_f(3, 2'd2) | pad_f(2, 3'd0, 1'b0, 1'b1));
    commit();
    tick();
    data_from_io = 4'b0100;
    #1;
    check("in_reg_same_cycle", {26'b0, data_to_ic}, 32'h00000000);
    tick();
    check("in_reg_next_cycle", {26'b0, data_to_ic}, 32'h00000008);

    shift_word(trk_f(3, 2'd2));
    commit();
    data_from_io = 4'b0000;
    #1;
    check("in_comb_lo", {26'b0, data_to_ic}, 32'h00000000);
    data_from_io = 4'b0100;
    #1;
    check("in_comb_hi", {26'b0, data_to_ic}, 32'h00000008);
    data_from_io = 4'b0000;

    // Shift + commit in one edge: active takes old shadow (pad0 osel=1),
    // shadow becomes shifted word with a 1 in, giving pad0 osel=3 later.
    shift_word(pad_f(0, 3'd1, 1'b0, 1'b0));
    config_enable = 1'b1;
    config_in     = 1'b1;
    config_commit = 1'b1;
    tick();
    config_enable = 1'b0;
    config_in     = 1'b0;
    config_commit = 1'b0;
    data_from_ic  = 6'b000010;
    #1;
    check("sc_old_shadow_sel1", {28'b0, data_to_io}, 32'h00000001);
    data_from_ic = 6'b001000;
    #1;
    check("sc_old_shadow_not3", {28'b0, data_to_io}, 32'h00000000);
    commit();
    check("sc_new_shadow_sel3", {28'b0, data_to_io}, 32'h00000001);
    data_from_ic = 6'b000010;
    #1;
    check("sc_new_shadow_not1", {28'b0, data_to_io}, 32'h00000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
